// File: rtl/ycr_dmi_arb_pkg.sv
// rtl/ycr_dmi_arb_pkg.sv - shared types and widths for the DM access arbiter
package ycr_dmi_arb_pkg;

    localparam int unsigned DMI_ADDR_W = 7;
    localparam int unsigned DMI_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DMI_ACC  = 2'd1,
        ST_HOST_ACC = 2'd2,
        ST_DONE     = 2'd3
    } arb_state_e;

    typedef enum logic {
        GNT_DMI  = 1'b0,
        GNT_HOST = 1'b1
    } arb_gnt_e;

endpackage

// File: rtl/ycr_dmi_arb.sv
// rtl/ycr_dmi_arb.sv - serialises JTAG DMI and host debug accesses onto the DM register port
module ycr_dmi_arb
    import ycr_dmi_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DMI_ADDR_W,
    parameter int unsigned DATA_W = DMI_DATA_W,
    parameter int unsigned TMO_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dmi_req_i,
    input  logic              dmi_wr_i,
    input  logic [ADDR_W-1:0] dmi_addr_i,
    input  logic [DATA_W-1:0] dmi_wdata_i,
    output logic [DATA_W-1:0] dmi_rdata_o,
    output logic              dmi_busy_o,
    output logic              dmi_err_o,
    input  logic              dmi_stat_clr_i,
    input  logic              host_req_i,
    input  logic              host_wr_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [DATA_W-1:0] host_wdata_i,
    output logic              host_ack_o,
    output logic [DATA_W-1:0] host_rdata_o,
    output logic              host_err_o,
    output logic              dm_req_o,
    output logic              dm_wr_o,
    output logic [ADDR_W-1:0] dm_addr_o,
    output logic [DATA_W-1:0] dm_wdata_o,
    input  logic              dm_resp_i,
    input  logic [DATA_W-1:0] dm_rdata_i
);

    arb_state_e        state;
    arb_state_e        state_nxt;
    arb_gnt_e          last_grant;

    logic              pend;
    logic              pend_wr;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_wdata;

    logic              acc_wr;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;

    logic [TMO_W-1:0]  tmo_cnt;
    logic [TMO_W-1:0]  tmo_inc;

    logic              in_acc;
    logic              tmo_hit;
    logic              dmi_accept;
    logic              grant_dmi;
    logic              grant_host;

    assign tmo_inc    = tmo_cnt + {{(TMO_W-1){1'b0}}, 1'b1};
    assign in_acc     = (state == ST_DMI_ACC) || (state == ST_HOST_ACC);
    // Abort on the cycle the counter would reach all-ones: 2^TMO_W-1 request cycles in total.
    assign tmo_hit    = in_acc && !dm_resp_i && (&tmo_inc);
    // A DMI pulse is only taken when the slot is free and no DMI access is in flight.
    assign dmi_accept = dmi_req_i && !pend && (state != ST_DMI_ACC);

    // DM port is driven straight from state; attributes are forced to zero outside an access.
    always_comb begin
        dm_req_o   = in_acc;
        dm_wr_o    = in_acc & acc_wr;
        dm_addr_o  = in_acc ? acc_addr  : '0;
        dm_wdata_o = in_acc ? acc_wdata : '0;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and grant decision; round-robin only matters when both sides want the DM.
    always_comb begin
        state_nxt  = state;
        grant_dmi  = 1'b0;
        grant_host = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pend && (!host_req_i || last_grant == GNT_HOST)) begin
                    grant_dmi = 1'b1;
                    state_nxt = ST_DMI_ACC;
                end else if (host_req_i) begin
                    grant_host = 1'b1;
                    state_nxt  = ST_HOST_ACC;
                end
            end
            ST_DMI_ACC, ST_HOST_ACC: begin
                if (dm_resp_i || tmo_hit) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Single-entry DMI slot: filled by an accepted pulse, emptied when granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend       <= 1'b0;
            pend_wr    <= 1'b0;
            pend_addr  <= '0;
            pend_wdata <= '0;
        end else if (dmi_accept) begin
            pend       <= 1'b1;
            pend_wr    <= dmi_wr_i;
            pend_addr  <= dmi_addr_i;
            pend_wdata <= dmi_wdata_i;
        end else if (grant_dmi) begin
            pend       <= 1'b0;
        end
    end

    // Latch the granted access, remember the winner and run the timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_wr     <= 1'b0;
            acc_addr   <= '0;
            acc_wdata  <= '0;
            tmo_cnt    <= '0;
            last_grant <= GNT_HOST;
        end else if (grant_dmi) begin
            acc_wr     <= pend_wr;
            acc_addr   <= pend_addr;
            acc_wdata  <= pend_wdata;
            tmo_cnt    <= '0;
            last_grant <= GNT_DMI;
        end else if (grant_host) begin
            acc_wr     <= host_wr_i;
            acc_addr   <= host_addr_i;
            acc_wdata  <= host_wdata_i;
            tmo_cnt    <= '0;
            last_grant <= GNT_HOST;
        end else if (in_acc && !dm_resp_i) begin
            tmo_cnt    <= tmo_inc;
        end
    end

    // Sticky DMI status; a new set event beats a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmi_busy_o <= 1'b0;
            dmi_err_o  <= 1'b0;
        end else begin
            if (dmi_req_i && !dmi_accept)              dmi_busy_o <= 1'b1;
            else if (dmi_stat_clr_i)                   dmi_busy_o <= 1'b0;
            if ((state == ST_DMI_ACC) && tmo_hit)      dmi_err_o  <= 1'b1;
            else if (dmi_stat_clr_i)                   dmi_err_o  <= 1'b0;
        end
    end

    // Completion capture: read data for reads only, host ack/err on both response and abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmi_rdata_o  <= '0;
            host_ack_o   <= 1'b0;
            host_rdata_o <= '0;
            host_err_o   <= 1'b0;
        end else begin
            host_ack_o <= (state == ST_HOST_ACC) && (dm_resp_i || tmo_hit);
            if ((state == ST_DMI_ACC) && dm_resp_i && !acc_wr) dmi_rdata_o <= dm_rdata_i;
            if ((state == ST_HOST_ACC) && dm_resp_i) begin
                if (!acc_wr) host_rdata_o <= dm_rdata_i;
                host_err_o <= 1'b0;
            end else if ((state == ST_HOST_ACC) && tmo_hit) begin
                host_rdata_o <= '0;
                host_err_o   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ycr_dmi_arb.sv
// tb/tb_ycr_dmi_arb.sv - scoreboard bench for the DM access arbiter
module tb_ycr_dmi_arb;

    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 32;
    localparam int TMO_W   = 4;
    localparam int TMO_CYC = 15;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              dmi_req_i = 1'b0;
    logic              dmi_wr_i = 1'b0;
    logic [ADDR_W-1:0] dmi_addr_i = '0;
    logic [DATA_W-1:0] dmi_wdata_i = '0;
    logic [DATA_W-1:0] dmi_rdata_o;
    logic              dmi_busy_o;
    logic              dmi_err_o;
    logic              dmi_stat_clr_i = 1'b0;
    logic              host_req_i = 1'b0;
    logic              host_wr_i = 1'b0;
    logic [ADDR_W-1:0] host_addr_i = '0;
    logic [DATA_W-1:0] host_wdata_i = '0;
    logic              host_ack_o;
    logic [DATA_W-1:0] host_rdata_o;
    logic              host_err_o;
    logic              dm_req_o;
    logic              dm_wr_o;
    logic [ADDR_W-1:0] dm_addr_o;
    logic [DATA_W-1:0] dm_wdata_o;
    logic              dm_resp_i;
    logic [DATA_W-1:0] dm_rdata_i;

    always #5 clk = ~clk;

    ycr_dmi_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TMO_W(TMO_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .dmi_req_i(dmi_req_i), .dmi_wr_i(dmi_wr_i), .dmi_addr_i(dmi_addr_i), .dmi_wdata_i(dmi_wdata_i),
        .dmi_rdata_o(dmi_rdata_o), .dmi_busy_o(dmi_busy_o), .dmi_err_o(dmi_err_o),
        .dmi_stat_clr_i(dmi_stat_clr_i),
        .host_req_i(host_req_i), .host_wr_i(host_wr_i), .host_addr_i(host_addr_i), .host_wdata_i(host_wdata_i),
        .host_ack_o(host_ack_o), .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
        .dm_req_o(dm_req_o), .dm_wr_o(dm_wr_o), .dm_addr_o(dm_addr_o), .dm_wdata_o(dm_wdata_o),
        .dm_resp_i(dm_resp_i), .dm_rdata_i(dm_rdata_i)
    );

    typedef struct {
        bit          host;
        bit          wr;
        logic [6:0]  addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
        bit          kill;
    } acc_t;

    acc_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   ack_cnt = 0;
    bit   in_acc = 1'b0;

    function automatic acc_t mk(bit host, bit wr, logic [6:0] addr, logic [31:0] wdata,
                                int lat, logic [31:0] rdata, bit kill);
        acc_t a;
        a.host = host; a.wr = wr; a.addr = addr; a.wdata = wdata;
        a.lat = lat; a.rdata = rdata; a.kill = kill;
        return a;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // DM responder and scoreboard monitor: pops the expected access when dm_req_o appears.
    initial begin
        acc_t        cur;
        int          cnt;
        logic [31:0] exp_dmi_rdata;
        logic [31:0] exp_host_rdata;
        cur = mk(0, 0, 0, 0, -1, 0, 1);
        cnt = 0;
        exp_dmi_rdata = 0;
        exp_host_rdata = 0;
        dm_resp_i = 1'b0;
        dm_rdata_i = '0;
        forever begin
            @(negedge clk);
            dm_resp_i = 1'b0;
            dm_rdata_i = '0;
            if (!rst_n) begin
                exp_dmi_rdata = 0;
                exp_host_rdata = 0;
            end
            if (dm_req_o && !in_acc) begin
                in_acc = 1'b1;
                cnt = 0;
                if (exp_q.size() == 0) begin
                    check("unexpected_dm_req", 64'd1, 64'd0);
                    cur = mk(0, 0, 0, 0, -1, 0, 1);
                end else begin
                    cur = exp_q.pop_front();
                    check("dm_wr", dm_wr_o, cur.wr);
                    check("dm_addr", dm_addr_o, cur.addr);
                    check("dm_wdata", dm_wdata_o, cur.wdata);
                end
            end
            if (in_acc) begin
                if (dm_req_o) begin
                    cnt++;
                    if (cur.lat >= 0 && cnt == cur.lat + 1) begin
                        dm_resp_i = 1'b1;
                        dm_rdata_i = cur.rdata;
                    end
                end else begin
                    in_acc = 1'b0;
                    if (!cur.kill) begin
                        check("dm_req_hold", cnt, (cur.lat >= 0) ? cur.lat + 1 : TMO_CYC);
                        check("dm_attr_idle", {dm_wr_o, dm_addr_o, dm_wdata_o}, 64'd0);
                        if (cur.host) begin
                            if (cur.lat < 0) exp_host_rdata = 0;
                            else if (!cur.wr) exp_host_rdata = cur.rdata;
                            check("host_ack", host_ack_o, 1);
                            check("host_rdata", host_rdata_o, exp_host_rdata);
                            check("host_err", host_err_o, (cur.lat < 0) ? 1 : 0);
                        end else begin
                            if (cur.lat >= 0 && !cur.wr) exp_dmi_rdata = cur.rdata;
                            check("dmi_rdata", dmi_rdata_o, exp_dmi_rdata);
                            check("dmi_err", dmi_err_o, (cur.lat < 0) ? 1 : 0);
                        end
                    end
                end
            end
        end
    end

    // Host ack monitor: counts acks and requires each to be a single-cycle pulse.
    initial begin
        bit prev_ack;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (host_ack_o) begin
                ack_cnt++;
                check("ack_single_pulse", prev_ack, 0);
            end
            prev_ack = host_ack_o;
        end
    end

    task automatic dmi_pulse(bit wr, logic [6:0] a, logic [31:0] d);
        dmi_req_i = 1'b1; dmi_wr_i = wr; dmi_addr_i = a; dmi_wdata_i = d;
        @(negedge clk);
        dmi_req_i = 1'b0; dmi_wr_i = 1'b0; dmi_addr_i = '0; dmi_wdata_i = '0;
    endtask

    task automatic host_op(bit wr, logic [6:0] a, logic [31:0] d);
        int n;
        n = 0;
        host_req_i = 1'b1; host_wr_i = wr; host_addr_i = a; host_wdata_i = d;
        @(negedge clk);
        while (!host_ack_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!host_ack_o) check("host_ack_timeout", 0, 1);
        host_req_i = 1'b0; host_wr_i = 1'b0; host_addr_i = '0; host_wdata_i = '0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || in_acc || dm_req_o) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("idle_timeout", 0, 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ack_before;
        repeat (3) @(negedge clk);
        check("rst_dm_req", dm_req_o, 0);
        check("rst_host_ack", host_ack_o, 0);
        check("rst_dmi_rdata", dmi_rdata_o, 0);
        check("rst_dmi_busy", dmi_busy_o, 0);
        check("rst_dmi_err", dmi_err_o, 0);
        check("rst_host_rdata", host_rdata_o, 0);
        check("rst_host_err", host_err_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Contention straight after reset: DMI wins, host follows.
        exp_q.push_back(mk(0, 0, 7'h20, 0, 1, 32'hA5A5_0001, 0));
        exp_q.push_back(mk(1, 0, 7'h21, 0, 0, 32'h1234_5678, 0));
        dmi_pulse(0, 7'h20, 0);
        host_op(0, 7'h21, 0);
        wait_idle();

        // DMI read, same-cycle response: request at N+2 only, data at N+3.
        exp_q.push_back(mk(0, 0, 7'h11, 0, 0, 32'hDEAD_BEEF, 0));
        dmi_pulse(0, 7'h11, 0);
        check("t1_req_n1", dm_req_o, 0);
        @(negedge clk);
        check("t1_req_n2", dm_req_o, 1);
        check("t1_addr_n2", dm_addr_o, 7'h11);
        @(negedge clk);
        check("t1_req_n3", dm_req_o, 0);
        check("t1_rdata_n3", dmi_rdata_o, 32'hDEAD_BEEF);
        wait_idle();

        // Contention after a DMI grant: host wins this time.
        exp_q.push_back(mk(1, 1, 7'h30, 32'h55, 2, 32'hFFFF_FFFF, 0));
        exp_q.push_back(mk(0, 0, 7'h31, 0, 0, 32'hCAFE_F00D, 0));
        dmi_pulse(0, 7'h31, 0);
        host_op(1, 7'h30, 32'h55);
        wait_idle();

        // Host write, DM answers after 3 cycles; host rdata keeps its old value.
        exp_q.push_back(mk(1, 1, 7'h04, 32'h1, 3, 32'h0BAD_0BAD, 0));
        fork
            host_op(1, 7'h04, 32'h1);
            begin
                check("hw_req_m", dm_req_o, 0);
                @(negedge clk);
                check("hw_req_m1", dm_req_o, 1);
            end
        join
        wait_idle();

        // Second DMI pulse while the first is in flight is dropped and flagged busy.
        exp_q.push_back(mk(0, 1, 7'h05, 32'h77, 5, 32'h1111_1111, 0));
        dmi_pulse(1, 7'h05, 32'h77);
        @(negedge clk);
        @(negedge clk);
        check("busy_before", dmi_busy_o, 0);
        dmi_pulse(0, 7'h7F, 0);
        check("busy_set", dmi_busy_o, 1);
        dmi_stat_clr_i = 1'b1;
        @(negedge clk);
        dmi_stat_clr_i = 1'b0;
        check("busy_clr", dmi_busy_o, 0);
        wait_idle();

        // DMI timeout: DM never answers.
        exp_q.push_back(mk(0, 0, 7'h06, 0, -1, 0, 0));
        dmi_pulse(0, 7'h06, 0);
        wait_idle();
        check("dmi_err_sticky", dmi_err_o, 1);
        dmi_stat_clr_i = 1'b1;
        @(negedge clk);
        dmi_stat_clr_i = 1'b0;
        check("dmi_err_clr", dmi_err_o, 0);

        // Host timeout: ack with error and zero data.
        exp_q.push_back(mk(1, 0, 7'h07, 0, -1, 0, 0));
        host_op(0, 7'h07, 0);
        wait_idle();

        // Reset in the middle of a host access with a DMI request pending.
        ack_before = ack_cnt;
        exp_q.push_back(mk(1, 0, 7'h08, 0, -1, 0, 1));
        host_req_i = 1'b1; host_addr_i = 7'h08;
        @(negedge clk);
        @(negedge clk);
        dmi_pulse(0, 7'h09, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_dm_req", dm_req_o, 0);
        check("rst_mid_host_ack", host_ack_o, 0);
        check("rst_mid_dm_addr", dm_addr_o, 0);
        host_req_i = 1'b0; host_addr_i = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_no_ack", ack_cnt, ack_before);
        check("rst_no_pending", dm_req_o, 0);
        check("rst_host_rdata_after", host_rdata_o, 0);

        // Normal host read after reset.
        exp_q.push_back(mk(1, 0, 7'h0A, 0, 1, 32'h0BAD_F00D, 0));
        host_op(0, 7'h0A, 0);
        wait_idle();
        check("ack_total", ack_cnt, 5);
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
